// File: rtl/decode_stage.sv
// RV32I(+M, Zicsr) decoder with registered outputs; 1-cycle latency, 2-entry skid buffer.
// Backpressure: in_ready is the registered inverse of skid-valid; outputs hold while stalled.
module decode_stage #(
  parameter bit EN_M      = 1'b0,
  parameter bit EN_ZICSR  = 1'b1,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [31:0]          in_pc,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [31:0]          out_pc,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic                 alu_src_b,
  output logic                 mem_write,
  output logic                 mem_read,
  output logic                 branch,
  output logic                 jump,
  output logic                 jump_lr,
  output logic                 mem_sign,
  output logic                 is_muldiv,
  output logic                 is_csr,
  output logic                 is_system,
  output logic                 illegal,
  output logic [1:0]           mem_to_reg,
  output logic [2:0]           imm_src,
  output logic [1:0]           alu_op,
  output logic [1:0]           mem_size,
  output logic [ILL_CNT_W-1:0] ill_count
);

  typedef struct packed {
    logic       reg_write;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       mem_write;
    logic       mem_read;
    logic       branch;
    logic       jump;
    logic       jump_lr;
    logic       mem_sign;
    logic       is_muldiv;
    logic       is_csr;
    logic       is_system;
    logic       illegal;
    logic [1:0] mem_to_reg;
    logic [2:0] imm_src;
    logic [1:0] alu_op;
    logic [1:0] mem_size;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    ctrl_t       ctrl;
  } entry_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  function automatic ctrl_t ctrl_default();
    ctrl_t c;
    c            = '0;
    c.mem_to_reg = 2'b01;
    c.mem_size   = 2'b10;
    c.mem_sign   = 1'b1;
    return c;
  endfunction

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  ctrl_t      dec;

  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];

  always_comb begin
    dec = ctrl_default();
    case (opc)
      OPC_OP: begin
        dec.reg_write = 1'b1;
        dec.alu_src_a = 1'b1;
        dec.alu_op    = 2'b10;
        if (f7 == 7'b0000000) begin
          dec.illegal = 1'b0;
        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
          dec.illegal = 1'b0;
        end else if (EN_M && f7 == 7'b0000001) begin
          dec.is_muldiv = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OPC_OPIMM: begin
        dec.reg_write = 1'b1;
        dec.alu_src_a = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.alu_op    = 2'b10;
      end
      OPC_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.alu_src_a  = 1'b1;
        dec.alu_src_b  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 2'b10;
        dec.mem_size   = f3[1:0];
        dec.mem_sign   = ~f3[2];
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) dec.illegal = 1'b1;
      end
      OPC_STORE: begin
        dec.alu_src_a = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.mem_write = 1'b1;
        dec.imm_src   = 3'b001;
        dec.mem_size  = f3[1:0];
        if (f3 > 3'b010) dec.illegal = 1'b1;
      end
      OPC_LUI: begin
        dec.reg_write = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.imm_src   = 3'b100;
        dec.alu_op    = 2'b11;
      end
      OPC_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.imm_src   = 3'b100;
      end
      OPC_BRANCH: begin
        dec.alu_src_b = 1'b1;
        dec.branch    = 1'b1;
        dec.imm_src   = 3'b010;
        dec.alu_op    = 2'b01;
        if (f3 == 3'b010 || f3 == 3'b011) dec.illegal = 1'b1;
      end
      OPC_JAL: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.alu_src_b  = 1'b1;
        dec.mem_to_reg = 2'b00;
        dec.imm_src    = 3'b011;
      end
      OPC_JALR: begin
        dec.reg_write  = 1'b1;
        dec.jump_lr    = 1'b1;
        dec.alu_src_a  = 1'b1;
        dec.alu_src_b  = 1'b1;
        dec.mem_to_reg = 2'b00;
        if (f3 != 3'b000) dec.illegal = 1'b1;
      end
      OPC_SYSTEM: begin
        if (f3 == 3'b000) begin
          dec.is_system = 1'b1;
        end else if (EN_ZICSR && f3 != 3'b100) begin
          dec.reg_write  = 1'b1;
          dec.alu_src_a  = 1'b1;
          dec.mem_to_reg = 2'b11;
          dec.is_csr     = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OPC_FENCE: dec.illegal = 1'b0;
      default:   dec.illegal = 1'b1;
    endcase
    // An illegal instruction must never produce architectural side effects downstream.
    if (dec.illegal) begin
      dec.reg_write = 1'b0;
      dec.mem_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
      dec.jump_lr   = 1'b0;
      dec.is_csr    = 1'b0;
      dec.is_muldiv = 1'b0;
    end
  end

  entry_t                 main_q, main_d, skid_q, skid_d, new_entry;
  logic                   main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic                   in_rdy_q;
  logic [ILL_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   acc;

  assign new_entry = '{instr: in_instr, pc: in_pc, ctrl: dec};
  assign acc       = in_valid && in_rdy_q && !flush;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    cnt_d      = cnt_q;
    if (acc && dec.illegal && !(&cnt_q)) cnt_d = cnt_q + {{(ILL_CNT_W-1){1'b0}}, 1'b1};
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (skid_vld_q) begin
      if (out_ready) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (!main_vld_q || out_ready) begin
      main_vld_d = acc;
      if (acc) main_d = new_entry;
    end else if (acc) begin
      skid_d     = new_entry;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q     <= '{instr: '0, pc: '0, ctrl: ctrl_default()};
      skid_q     <= '{instr: '0, pc: '0, ctrl: ctrl_default()};
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_rdy_q   <= 1'b1;
      cnt_q      <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      in_rdy_q   <= ~skid_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready   = in_rdy_q;
  assign out_valid  = main_vld_q;
  assign out_instr  = main_q.instr;
  assign out_pc     = main_q.pc;
  assign reg_write  = main_q.ctrl.reg_write;
  assign alu_src_a  = main_q.ctrl.alu_src_a;
  assign alu_src_b  = main_q.ctrl.alu_src_b;
  assign mem_write  = main_q.ctrl.mem_write;
  assign mem_read   = main_q.ctrl.mem_read;
  assign branch     = main_q.ctrl.branch;
  assign jump       = main_q.ctrl.jump;
  assign jump_lr    = main_q.ctrl.jump_lr;
  assign mem_sign   = main_q.ctrl.mem_sign;
  assign is_muldiv  = main_q.ctrl.is_muldiv;
  assign is_csr     = main_q.ctrl.is_csr;
  assign is_system  = main_q.ctrl.is_system;
  assign illegal    = main_q.ctrl.illegal;
  assign mem_to_reg = main_q.ctrl.mem_to_reg;
  assign imm_src    = main_q.ctrl.imm_src;
  assign alu_op     = main_q.ctrl.alu_op;
  assign mem_size   = main_q.ctrl.mem_size;
  assign ill_count  = cnt_q;

endmodule
